// File: rtl/parity_updown_counter_pkg.sv
// Shared mode/direction encodings and parity helpers for the parity up/down counter.
package parity_updown_counter_pkg;

    localparam logic [1:0] MODE_EVEN = 2'd0;
    localparam logic [1:0] MODE_ODD  = 2'd1;
    localparam logic [1:0] MODE_ALL  = 2'd2;
    localparam logic       DIR_UP    = 1'b0;
    localparam logic       DIR_DOWN  = 1'b1;

    // LSB value every count must carry in a parity-restricted mode
    function automatic logic mode_lsb(input logic [1:0] mode);
        return (mode == MODE_ODD) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic is_parity_mode(input logic [1:0] mode);
        return (mode == MODE_EVEN) || (mode == MODE_ODD);
    endfunction

endpackage

// File: rtl/parity_updown_counter_dff_sync.sv
// Single-bit D flip-flop with synchronous active-high clear; the storage cell of the counter.
module parity_updown_counter_dff_sync (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    // storage bit with synchronous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/parity_updown_counter.sv
// Up/down counter with even/odd/all counting modes, load, wrap-or-saturate limits,
// a terminal-count flag and a registered wrap pulse for cascading.
module parity_updown_counter
    import parity_updown_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             y,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [WIDTH:0] MAX_EXT = {1'b0, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] state_r;
    logic [WIDTH-1:0] next_state_s;
    logic             wrapped_r;
    logic             next_wrapped_s;
    logic [WIDTH:0]   cur_ext_s;
    logic [WIDTH:0]   lower_s;
    logic [WIDTH:0]   upper_s;
    logic [WIDTH:0]   step_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             parity_mode_s;
    logic             par_bit_s;
    logic             aligned_s;
    logic             past_upper_s;
    logic             past_lower_s;

    // mode-dependent limits, step and the one-bit-wider trial results
    always_comb begin
        parity_mode_s = is_parity_mode(mode);
        par_bit_s     = mode_lsb(mode);
        cur_ext_s     = {1'b0, state_r};
        aligned_s     = parity_mode_s ? (state_r[0] == par_bit_s) : 1'b1;
        case (mode)
            MODE_EVEN: begin
                lower_s = {(WIDTH+1){1'b0}};
                upper_s = {MAX_EXT[WIDTH:1], 1'b0};
                step_s  = {{(WIDTH-1){1'b0}}, 2'd2};
            end
            MODE_ODD: begin
                lower_s = {{WIDTH{1'b0}}, 1'b1};
                upper_s = MAX_EXT;
                step_s  = {{(WIDTH-1){1'b0}}, 2'd2};
            end
            default: begin
                lower_s = {(WIDTH+1){1'b0}};
                upper_s = MAX_EXT;
                step_s  = {{WIDTH{1'b0}}, 1'b1};
            end
        endcase
        sum_s  = cur_ext_s + step_s;
        diff_s = cur_ext_s - step_s;
        // a borrow out of the extended subtraction also means we stepped below the floor
        past_upper_s = (sum_s > upper_s);
        past_lower_s = diff_s[WIDTH] || (diff_s < lower_s);
        tc = en && aligned_s &&
             ((y == DIR_DOWN) ? (cur_ext_s == lower_s) : (cur_ext_s == upper_s));
    end

    // next count and wrap pulse; reset is applied inside the storage cells
    always_comb begin
        next_state_s   = state_r;
        next_wrapped_s = 1'b0;
        if (load) begin
            next_state_s = parity_mode_s ? {load_value[WIDTH-1:1], par_bit_s} : load_value;
        end else if (en) begin
            if (!aligned_s) begin
                next_state_s = {state_r[WIDTH-1:1], par_bit_s};
            end else if (y == DIR_UP) begin
                if (!past_upper_s) begin
                    next_state_s = sum_s[WIDTH-1:0];
                end else if (WRAP) begin
                    next_state_s   = lower_s[WIDTH-1:0];
                    next_wrapped_s = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end else begin
                if (!past_lower_s) begin
                    next_state_s = diff_s[WIDTH-1:0];
                end else if (WRAP) begin
                    next_state_s   = upper_s[WIDTH-1:0];
                    next_wrapped_s = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
        end else begin
            next_state_s = state_r;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_state
        parity_updown_counter_dff_sync u_bit (
            .clock (clock),
            .reset (reset),
            .d     (next_state_s[i]),
            .q     (state_r[i])
        );
    end

    parity_updown_counter_dff_sync u_wrapped (
        .clock (clock),
        .reset (reset),
        .d     (next_wrapped_s),
        .q     (wrapped_r)
    );

    assign state   = state_r;
    assign wrapped = wrapped_r;

endmodule

// File: tb/tb_parity_updown_counter.sv
// Directed bench for parity_updown_counter: a wrapping and a saturating instance share stimulus.
module tb_parity_updown_counter;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic         y = 1'b0;
    logic         load = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] state_a, state_b;
    logic         tc_a, tc_b, wr_a, wr_b;

    int total = 0;
    int bad   = 0;

    int  ms [2];
    bit  mw [2];
    bit  mvalid = 1'b0;

    typedef struct packed {
        logic [W-1:0] sa;
        logic         wa;
        logic [W-1:0] sb;
        logic         wb;
    } exp_t;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    parity_updown_counter #(.WIDTH(W), .WRAP(1'b1)) dut_a (
        .clock(clock), .reset(reset), .en(en), .y(y), .mode(mode), .load(load),
        .load_value(load_value), .state(state_a), .tc(tc_a), .wrapped(wr_a)
    );

    parity_updown_counter #(.WIDTH(W), .WRAP(1'b0)) dut_b (
        .clock(clock), .reset(reset), .en(en), .y(y), .mode(mode), .load(load),
        .load_value(load_value), .state(state_b), .tc(tc_b), .wrapped(wr_b)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int lo_of(input logic [1:0] m);
        return (m == 2'd1) ? 1 : 0;
    endfunction

    function automatic int hi_of(input logic [1:0] m);
        return (m == 2'd0) ? (1 << W) - 2 : (1 << W) - 1;
    endfunction

    function automatic bit aligned_of(input int s, input logic [1:0] m);
        return (m >= 2'd2) || ((s % 2) == int'(m));
    endfunction

    function automatic bit model_tc(input int idx);
        if (!en || !aligned_of(ms[idx], mode)) return 1'b0;
        return y ? (ms[idx] == lo_of(mode)) : (ms[idx] == hi_of(mode));
    endfunction

    function automatic void model_next(input int idx, input bit wrap_en);
        int stp;
        stp = (mode < 2'd2) ? 2 : 1;
        mw[idx] = 1'b0;
        if (reset) begin
            ms[idx] = 0;
        end else if (load) begin
            ms[idx] = (mode < 2'd2) ? ((int'(load_value) / 2) * 2 + int'(mode)) : int'(load_value);
        end else if (en) begin
            if (!aligned_of(ms[idx], mode)) begin
                ms[idx] = (ms[idx] / 2) * 2 + int'(mode);
            end else if (!y) begin
                if (ms[idx] + stp <= hi_of(mode)) ms[idx] = ms[idx] + stp;
                else if (wrap_en) begin ms[idx] = lo_of(mode); mw[idx] = 1'b1; end
            end else begin
                if (ms[idx] - stp >= lo_of(mode)) ms[idx] = ms[idx] - stp;
                else if (wrap_en) begin ms[idx] = hi_of(mode); mw[idx] = 1'b1; end
            end
        end
    endfunction

    task automatic step(input logic r, input logic l, input logic e, input logic yy,
                        input logic [1:0] m, input logic [W-1:0] lv);
        exp_t ex;
        @(negedge clock);
        reset = r; load = l; en = e; y = yy; mode = m; load_value = lv;
        #1;
        if (mvalid) begin
            check("tc_a", {3'd0, tc_a}, {3'd0, model_tc(0)});
            check("tc_b", {3'd0, tc_b}, {3'd0, model_tc(1)});
        end
        if (r) mvalid = 1'b1;
        if (mvalid) begin
            model_next(0, 1'b1);
            model_next(1, 1'b0);
            sb_q.push_back('{sa: W'(ms[0]), wa: mw[0], sb: W'(ms[1]), wb: mw[1]});
        end
        @(posedge clock);
        #1;
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            check("state_a", state_a, ex.sa);
            check("wrapped_a", {3'd0, wr_a}, {3'd0, ex.wa});
            check("state_b", state_b, ex.sb);
            check("wrapped_b", {3'd0, wr_b}, {3'd0, ex.wb});
        end
    endtask

    initial begin
        // even up-count through the wrap
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
        check("reset_state", state_a, 4'd0);
        check("reset_wrapped", {3'd0, wr_a}, 4'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0);
            if (i == 6) begin
                check("t1_at14", state_a, 4'd14);
                check("t1_tc14", {3'd0, tc_a}, 4'd1);
            end
            if (i == 7) begin
                check("t1_wrap0", state_a, 4'd0);
                check("t1_wrpulse", {3'd0, wr_a}, 4'd1);
                check("t1_sat_b", state_b, 4'd14);
            end
            if (i == 8) check("t1_pulse_end", {3'd0, wr_a}, 4'd0);
        end

        // odd mode down from reset: alignment step, then wrap to 15
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd0);
            if (i == 0) begin
                check("t2_align", state_a, 4'd1);
                check("t2_align_wr", {3'd0, wr_a}, 4'd0);
            end
            if (i == 1) begin
                check("t2_wrap15", state_a, 4'd15);
                check("t2_wrpulse", {3'd0, wr_a}, 4'd1);
            end
            if (i == 3) check("t2_at11", state_a, 4'd11);
        end

        // all mode, saturate at 15 on the non-wrapping instance
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 4'hE);
        check("t3_load", state_b, 4'd14);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0);
            check("t3_sat", state_b, 4'd15);
            check("t3_nowrap", {3'd0, wr_b}, 4'd0);
            check("t3_tc", {3'd0, tc_b}, 4'd1);
        end

        // load beats count, with even alignment of the loaded value
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'd7);
        check("t4_load6", state_a, 4'd6);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 4'd0);
        check("t4_down4", state_b, 4'd4);

        // reset beats load
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd5);
        check("t5_reset", state_a, 4'd0);
        check("t5_reset_wr", {3'd0, wr_a}, 4'd0);

        // hold with en low while y toggles
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd8);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'(i % 2), 2'd0, 4'd0);
            check("t6_hold", state_a, 4'd8);
            check("t6_tc", {3'd0, tc_a}, 4'd0);
        end

        // reserved mode counts by one; switching to odd triggers an alignment step
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0);
        check("t7_mode3", state_a, 4'd6);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0);
        check("t7_realign", state_a, 4'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd0);
        check("t7_odd_up", state_a, 4'd9);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
